// File: rtl/handshaked_pattern_source_if.sv
// Valid/ready word stream from the pattern source to its consumer.
// The master drives data/vld/last; the slave answers with rd.
interface handshaked_pattern_source_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  vld;
  logic                  last;
  logic                  rd;

  modport master (
    output data,
    output vld,
    output last,
    input  rd
  );

  modport slave (
    input  data,
    input  vld,
    input  last,
    output rd
  );
endinterface

// File: rtl/handshaked_pattern_source.sv
// Handshaked incrementing-pattern burst source.
// On start (while idle) captures len/seed/gap, then emits len words seed, seed+1, ...
// over a valid/ready stream, optionally inserting gap idle cycles after each
// non-final word, and finishes with a single-cycle done pulse.
module handshaked_pattern_source #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned GAP_WIDTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [LEN_WIDTH-1:0]                len,
  input  logic [DATA_WIDTH-1:0]               seed,
  input  logic [GAP_WIDTH-1:0]                gap,
  handshaked_pattern_source_if.master         dataOut,
  output logic                                busy,
  output logic                                done
);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap,
    StDone
  } stateT;

  stateT                 stateQ, stateD;
  logic [DATA_WIDTH-1:0] wordQ, wordD;
  // Words still to be transferred, including the one currently presented.
  // Counting down from len avoids needing a wider counter for len = 2^LEN_WIDTH-1.
  logic [LEN_WIDTH-1:0]  remainQ, remainD;
  logic [GAP_WIDTH-1:0]  gapLenQ, gapLenD;
  logic [GAP_WIDTH-1:0]  gapCntQ, gapCntD;

  logic sending;
  logic isLast;

  assign sending = (stateQ == StSend);
  assign isLast  = (remainQ == LEN_WIDTH'(1));

  // State and burst-context registers; reset aborts any burst immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ  <= StIdle;
      wordQ   <= '0;
      remainQ <= '0;
      gapLenQ <= '0;
      gapCntQ <= '0;
    end else begin
      stateQ  <= stateD;
      wordQ   <= wordD;
      remainQ <= remainD;
      gapLenQ <= gapLenD;
      gapCntQ <= gapCntD;
    end
  end

  // Next-state logic: burst capture, per-transfer advance and gap countdown.
  always_comb begin
    stateD  = stateQ;
    wordD   = wordQ;
    remainD = remainQ;
    gapLenD = gapLenQ;
    gapCntD = gapCntQ;

    unique case (stateQ)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            stateD  = StSend;
            wordD   = seed;
            remainD = len;
            gapLenD = gap;
            gapCntD = '0;
          end else begin
            stateD = StDone;
          end
        end
      end

      StSend: begin
        if (dataOut.rd) begin
          if (isLast) begin
            // No gap after the final word.
            stateD  = StDone;
            remainD = '0;
          end else begin
            wordD   = wordQ + DATA_WIDTH'(1);
            remainD = remainQ - LEN_WIDTH'(1);
            if (gapLenQ != '0) begin
              stateD  = StGap;
              gapCntD = gapLenQ;
            end
          end
        end
      end

      StGap: begin
        gapCntD = gapCntQ - GAP_WIDTH'(1);
        if (gapCntQ == GAP_WIDTH'(1)) begin
          stateD = StSend;
        end
      end

      StDone: begin
        stateD = StIdle;
      end

      default: begin
        stateD = StIdle;
      end
    endcase
  end

  // Outputs decode from registered state only, so vld never depends on rd.
  always_comb begin
    dataOut.vld  = sending;
    dataOut.data = sending ? wordQ : '0;
    dataOut.last = sending && isLast;
    busy         = (stateQ != StIdle);
    done         = (stateQ == StDone);
  end

endmodule
